// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared encodings, decoded-instruction and ID/EX record types, and the
// combinational instruction decoder used by the decode stage.
package id_ex_fwd_stage_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  // SPECIAL function codes
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SYNC = 6'b001111;

  // ALU subtypes and result types
  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP = 8'b00000011;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        re1;
    logic        re2;
    logic [31:0] imm1;     // operand 1 when port 1 is not read
    logic [31:0] imm2;     // operand 2 when port 2 is not read
    logic [4:0]  wd;
    logic        wreg;
    logic        is_load;
    logic        invalid;
  } dec_t;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        is_load;
    logic [31:0] pc;
    logic        invalid;
  } idex_t;

  function automatic idex_t bubble();
    idex_t b;
    b        = '0;
    b.aluop  = EXE_NOP_OP;
    b.alusel = EXE_RES_NOP;
    return b;
  endfunction

  // Pure function of the instruction word; forwarding is applied elsewhere.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t        d;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    op       = inst[31:26];
    fn       = inst[5:0];
    imm      = inst[15:0];
    d        = '0;
    d.aluop  = EXE_NOP_OP;
    d.alusel = EXE_RES_NOP;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.aluop  = (op == OP_ANDI) ? EXE_AND_OP : (op == OP_ORI) ? EXE_OR_OP : EXE_XOR_OP;
        d.alusel = EXE_RES_LOGIC;
        d.re1    = 1'b1;
        d.imm2   = {16'h0, imm};
        d.wd     = inst[20:16];
        d.wreg   = 1'b1;
      end
      OP_LUI: begin
        d.aluop  = EXE_OR_OP;
        d.alusel = EXE_RES_LOGIC;
        d.re1    = 1'b1;
        d.imm2   = {imm, 16'h0};
        d.wd     = inst[20:16];
        d.wreg   = 1'b1;
      end
      OP_LW: begin
        d.aluop   = EXE_LW_OP;
        d.alusel  = EXE_RES_LOAD_STORE;
        d.re1     = 1'b1;
        d.imm2    = {{16{imm[15]}}, imm};
        d.wd      = inst[20:16];
        d.wreg    = 1'b1;
        d.is_load = 1'b1;
      end
      OP_PREF: ;  // architectural NOP
      OP_SPECIAL: begin
        case (fn)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            d.aluop  = (fn == FN_AND) ? EXE_AND_OP : (fn == FN_OR) ? EXE_OR_OP :
                       (fn == FN_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
            d.alusel = EXE_RES_LOGIC;
            d.re1    = 1'b1;
            d.re2    = 1'b1;
            d.wd     = inst[15:11];
            d.wreg   = 1'b1;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            d.aluop  = (fn == FN_SLLV) ? EXE_SLL_OP : (fn == FN_SRLV) ? EXE_SRL_OP : EXE_SRA_OP;
            d.alusel = EXE_RES_SHIFT;
            d.re1    = 1'b1;
            d.re2    = 1'b1;
            d.wd     = inst[15:11];
            d.wreg   = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            // shift amount comes from the sa field, not the register file
            d.aluop  = (fn == FN_SLL) ? EXE_SLL_OP : (fn == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
            d.alusel = EXE_RES_SHIFT;
            d.re2    = 1'b1;
            d.imm1   = {27'b0, inst[10:6]};
            d.wd     = inst[15:11];
            d.wreg   = 1'b1;
          end
          FN_SYNC: ;  // architectural NOP
          default: d.invalid = 1'b1;
        endcase
      end
      default: d.invalid = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_ex_fwd_stage_fwd_mux.sv
// Operand source select for one register-file read port: $0 is hard zero,
// otherwise the youngest matching producer wins, else the register file.
module id_fwd_mux
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]            i_addr,
  input  logic [31:0]           i_rf_data,
  input  logic [NUM_FWD-1:0]    i_wreg,
  input  logic [5*NUM_FWD-1:0]  i_wd,
  input  logic [32*NUM_FWD-1:0] i_wdata,
  output logic [31:0]           o_data
);

  // scan oldest to youngest so the lowest-index match is the last to override
  always_comb begin
    o_data = i_rf_data;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (i_wreg[k] && (i_wd[5*k +: 5] == i_addr)) o_data = i_wdata[32*k +: 32];
    end
    if (i_addr == 5'd0) o_data = 32'h0;
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// MIPS32 decode stage with operand forwarding, load-use stall detection,
// built-in ID/EX register and a saturating stall-cycle counter.
module id_ex_fwd_stage
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           reg1_data_i,
  input  logic [31:0]           reg2_data_i,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [4:0]            reg1_addr_o,
  output logic [4:0]            reg2_addr_o,
  input  logic [NUM_FWD-1:0]    fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]  fwd_wd_i,
  input  logic [32*NUM_FWD-1:0] fwd_wdata_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_stall_i,
  input  logic                  flush_i,
  output logic                  stallreq_o,
  output logic [7:0]            aluop_o,
  output logic [2:0]            alusel_o,
  output logic [31:0]           reg1_o,
  output logic [31:0]           reg2_o,
  output logic [4:0]            wd_o,
  output logic                  wreg_o,
  output logic                  is_load_o,
  output logic [31:0]           pc_o,
  output logic                  inst_invalid_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  dec_t             w_dec;
  logic [31:0]      w_fwd1, w_fwd2;
  logic             w_haz1, w_haz2, w_hazard;
  idex_t            w_cap;
  idex_t            r_idex;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_dec       = decode(inst_i);
  assign reg1_read_o = w_dec.re1;
  assign reg2_read_o = w_dec.re2;
  assign reg1_addr_o = inst_i[25:21];
  assign reg2_addr_o = inst_i[20:16];

  id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd1 (
    .i_addr(reg1_addr_o), .i_rf_data(reg1_data_i), .i_wreg(fwd_wreg_i),
    .i_wd(fwd_wd_i), .i_wdata(fwd_wdata_i), .o_data(w_fwd1)
  );

  id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd2 (
    .i_addr(reg2_addr_o), .i_rf_data(reg2_data_i), .i_wreg(fwd_wreg_i),
    .i_wd(fwd_wd_i), .i_wdata(fwd_wdata_i), .o_data(w_fwd2)
  );

  // A load in EX has no data yet, so any real dependency on it must wait.
  assign w_haz1     = w_dec.re1 && (reg1_addr_o != 5'd0) && (reg1_addr_o == fwd_wd_i[4:0]);
  assign w_haz2     = w_dec.re2 && (reg2_addr_o != 5'd0) && (reg2_addr_o == fwd_wd_i[4:0]);
  assign w_hazard   = valid_i && ex_is_load_i && fwd_wreg_i[0] && (w_haz1 || w_haz2);
  assign stallreq_o = w_hazard && !ex_stall_i;

  // assemble the record that a normal capture writes into ID/EX
  always_comb begin
    w_cap         = bubble();
    w_cap.aluop   = w_dec.aluop;
    w_cap.alusel  = w_dec.alusel;
    w_cap.reg1    = w_dec.re1 ? w_fwd1 : w_dec.imm1;
    w_cap.reg2    = w_dec.re2 ? w_fwd2 : w_dec.imm2;
    w_cap.wd      = w_dec.wd;
    w_cap.wreg    = w_dec.wreg;
    w_cap.is_load = w_dec.is_load;
    w_cap.pc      = pc_i;
    w_cap.invalid = w_dec.invalid;
  end

  // ID/EX register: flush beats a downstream hold; hazards insert bubbles
  always_ff @(posedge clk) begin
    if (rst)             r_idex <= bubble();
    else if (flush_i)    r_idex <= bubble();
    else if (ex_stall_i) r_idex <= r_idex;
    else if (w_hazard)   r_idex <= bubble();
    else if (valid_i)    r_idex <= w_cap;
    else                 r_idex <= bubble();
  end

  // saturating count of cycles lost to load-use stalls
  always_ff @(posedge clk) begin
    if (rst)                                              r_stall_cnt <= '0;
    else if (!flush_i && stallreq_o && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign aluop_o        = r_idex.aluop;
  assign alusel_o       = r_idex.alusel;
  assign reg1_o         = r_idex.reg1;
  assign reg2_o         = r_idex.reg2;
  assign wd_o           = r_idex.wd;
  assign wreg_o         = r_idex.wreg;
  assign is_load_o      = r_idex.is_load;
  assign pc_o           = r_idex.pc;
  assign inst_invalid_o = r_idex.invalid;
  assign stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Randomized and directed checks of id_ex_fwd_stage against a behavioural model.
module tb_id_ex_fwd_stage;
  import id_ex_fwd_stage_pkg::*;

  localparam int NF = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_i = 1'b0;
  logic [31:0]     pc_i = '0, inst_i = '0, reg1_data_i = '0, reg2_data_i = '0;
  logic [NF-1:0]   fwd_wreg_i = '0;
  logic [5*NF-1:0] fwd_wd_i = '0;
  logic [32*NF-1:0] fwd_wdata_i = '0;
  logic            ex_is_load_i = 1'b0, ex_stall_i = 1'b0, flush_i = 1'b0;

  logic reg1_read_o, reg2_read_o, stallreq_o, wreg_o, is_load_o, inst_invalid_o;
  logic [4:0] reg1_addr_o, reg2_addr_o, wd_o;
  logic [7:0] aluop_o; logic [2:0] alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [15:0] stall_cnt_o;

  logic b_reg1_read_o, b_reg2_read_o, b_stallreq_o, b_wreg_o, b_is_load_o, b_inst_invalid_o;
  logic [4:0] b_reg1_addr_o, b_reg2_addr_o, b_wd_o;
  logic [7:0] b_aluop_o; logic [2:0] b_alusel_o;
  logic [31:0] b_reg1_o, b_reg2_o, b_pc_o;
  logic [1:0] b_stall_cnt_o;

  id_ex_fwd_stage #(.NUM_FWD(NF), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_is_load_i(ex_is_load_i), .ex_stall_i(ex_stall_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .is_load_o(is_load_o), .pc_o(pc_o), .inst_invalid_o(inst_invalid_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // narrow-counter instance sharing all inputs, used for saturation
  id_ex_fwd_stage #(.NUM_FWD(NF), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg1_read_o(b_reg1_read_o), .reg2_read_o(b_reg2_read_o),
    .reg1_addr_o(b_reg1_addr_o), .reg2_addr_o(b_reg2_addr_o),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_is_load_i(ex_is_load_i), .ex_stall_i(ex_stall_i), .flush_i(flush_i),
    .stallreq_o(b_stallreq_o), .aluop_o(b_aluop_o), .alusel_o(b_alusel_o),
    .reg1_o(b_reg1_o), .reg2_o(b_reg2_o), .wd_o(b_wd_o), .wreg_o(b_wreg_o),
    .is_load_o(b_is_load_o), .pc_o(b_pc_o), .inst_invalid_o(b_inst_invalid_o),
    .stall_cnt_o(b_stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1, r2, pc;
    logic [4:0]  wd;
    logic        wreg, ld, inv;
  } ex_t;

  function automatic ex_t zero_ex();
    ex_t e;
    e.aluop = 8'h00; e.alusel = 3'h0; e.r1 = 0; e.r2 = 0; e.pc = 0;
    e.wd = 0; e.wreg = 0; e.ld = 0; e.inv = 0;
    return e;
  endfunction

  function automatic logic [7:0] lop(input logic [1:0] i);
    case (i)
      2'd0: return EXE_AND_OP;
      2'd1: return EXE_OR_OP;
      2'd2: return EXE_XOR_OP;
      default: return EXE_NOR_OP;
    endcase
  endfunction

  function automatic logic [7:0] sop(input logic [1:0] i);
    case (i)
      2'd2: return EXE_SRL_OP;
      2'd3: return EXE_SRA_OP;
      default: return EXE_SLL_OP;
    endcase
  endfunction

  // youngest (lowest channel) producer of the register wins; $0 is zero
  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'h0;
    for (int k = 0; k < NF; k++)
      if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == a) return fwd_wdata_i[32*k +: 32];
    return rf;
  endfunction

  function automatic void m_decode(input logic [31:0] ins, output ex_t e,
                                   output logic u1, output logic u2);
    logic [5:0] op, fn; logic [4:0] rs, rt, rd; logic [15:0] im; logic [31:0] i1, i2;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; im = ins[15:0];
    e = zero_ex(); u1 = 0; u2 = 0; i1 = 0; i2 = 0;
    case (op)
      6'h0c, 6'h0d, 6'h0e: begin
        e.aluop = lop(op[1:0]); e.alusel = EXE_RES_LOGIC; u1 = 1;
        i2 = {16'h0, im}; e.wd = rt; e.wreg = 1;
      end
      6'h0f: begin
        e.aluop = EXE_OR_OP; e.alusel = EXE_RES_LOGIC; u1 = 1;
        i2 = {im, 16'h0}; e.wd = rt; e.wreg = 1;
      end
      6'h23: begin
        e.aluop = EXE_LW_OP; e.alusel = EXE_RES_LOAD_STORE; u1 = 1;
        i2 = {{16{im[15]}}, im}; e.wd = rt; e.wreg = 1; e.ld = 1;
      end
      6'h33: ;
      6'h00: begin
        if (fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
          e.aluop = lop(fn[1:0]); e.alusel = EXE_RES_LOGIC; u1 = 1; u2 = 1; e.wd = rd; e.wreg = 1;
        end else if (fn inside {6'h04, 6'h06, 6'h07}) begin
          e.aluop = sop(fn[1:0]); e.alusel = EXE_RES_SHIFT; u1 = 1; u2 = 1; e.wd = rd; e.wreg = 1;
        end else if (fn inside {6'h00, 6'h02, 6'h03}) begin
          e.aluop = sop(fn[1:0]); e.alusel = EXE_RES_SHIFT; u2 = 1;
          i1 = {27'b0, ins[10:6]}; e.wd = rd; e.wreg = 1;
        end else if (fn != 6'h0f) e.inv = 1;
      end
      default: e.inv = 1;
    endcase
    e.r1 = u1 ? m_fwd(rs, reg1_data_i) : i1;
    e.r2 = u2 ? m_fwd(rt, reg2_data_i) : i2;
    e.pc = pc_i;
  endfunction

  function automatic logic m_hazard(input logic u1, input logic u2);
    logic [4:0] rs, rt, w0;
    rs = inst_i[25:21]; rt = inst_i[20:16]; w0 = fwd_wd_i[4:0];
    return valid_i && ex_is_load_i && fwd_wreg_i[0] &&
           ((u1 && rs != 0 && rs == w0) || (u2 && rt != 0 && rt == w0));
  endfunction

  ex_t m_st;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  initial begin
    m_st = zero_ex(); m_cnt = 0; m_cnt2 = 0;
  end

  always @(posedge clk) begin
    ex_t d; logic u1, u2, hz;
    m_decode(inst_i, d, u1, u2);
    hz = m_hazard(u1, u2);
    if (rst) begin
      m_st <= zero_ex(); m_cnt <= 0; m_cnt2 <= 0;
    end else begin
      if (!flush_i && hz && !ex_stall_i) begin
        if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 1;
        if (m_cnt2 != 2'd3) m_cnt2 <= m_cnt2 + 1;
      end
      if (flush_i)         m_st <= zero_ex();
      else if (ex_stall_i) m_st <= m_st;
      else if (hz)         m_st <= zero_ex();
      else if (valid_i)    m_st <= d;
      else                 m_st <= zero_ex();
    end
  end

  // compare every cycle, mid-period
  always @(negedge clk) begin
    ex_t d; logic u1, u2, hz;
    if (armed) begin
      m_decode(inst_i, d, u1, u2);
      hz = m_hazard(u1, u2);
      chk("aluop", aluop_o, m_st.aluop);
      chk("alusel", alusel_o, m_st.alusel);
      chk("reg1", reg1_o, m_st.r1);
      chk("reg2", reg2_o, m_st.r2);
      chk("wd", wd_o, m_st.wd);
      chk("wreg", wreg_o, m_st.wreg);
      chk("is_load", is_load_o, m_st.ld);
      chk("pc", pc_o, m_st.pc);
      chk("inv", inst_invalid_o, m_st.inv);
      chk("stall_cnt", stall_cnt_o, m_cnt);
      chk("stall_cnt2", b_stall_cnt_o, m_cnt2);
      chk("stallreq", stallreq_o, hz && !ex_stall_i);
      chk("re1", reg1_read_o, u1);
      chk("re2", reg2_read_o, u2);
      chk("addr1", reg1_addr_o, inst_i[25:21]);
      chk("addr2", reg2_addr_o, inst_i[20:16]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int k, input logic we, input logic [4:0] wd, input logic [31:0] dat);
    fwd_wreg_i[k] = we;
    fwd_wd_i[5*k +: 5] = wd;
    fwd_wdata_i[32*k +: 32] = dat;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [5:0] ops [10];
    logic [5:0] fns [12];
    logic [5:0] op, fn;
    ops = '{6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h33, 6'h00, 6'h00, 6'h00, 6'h3f};
    fns = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07, 6'h00, 6'h02, 6'h03, 6'h0f, 6'h3a};
    op = ops[$urandom_range(0, 9)];
    fn = fns[$urandom_range(0, 11)];
    if (op == 6'h00)
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom), fn};
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
  endfunction

  initial begin
    rst = 1; tick(); armed = 1; tick();
    rst = 0;

    // 1: ori $1,$0,0x1100
    valid_i = 1; pc_i = 32'h100; inst_i = 32'h34011100; reg1_data_i = 32'hDEADBEEF;
    tick();
    chk("t1 reg1", reg1_o, 32'h0);
    chk("t1 reg2", reg2_o, 32'h00001100);
    chk("t1 aluop", aluop_o, EXE_OR_OP);
    chk("t1 wd", wd_o, 5'd1);
    chk("t1 wreg", wreg_o, 1'b1);

    // 2: or $3,$1,$2 with both channels writing $1
    inst_i = 32'h00221825; pc_i = 32'h104; reg2_data_i = 32'd7;
    set_ch(0, 1, 5'd1, 32'hAAAA0000); set_ch(1, 1, 5'd1, 32'h00005555);
    tick();
    chk("t2 reg1", reg1_o, 32'hAAAA0000);
    chk("t2 reg2", reg2_o, 32'd7);
    chk("t2 wd", wd_o, 5'd3);

    // 3: and $5,$4,$6 behind a load of $4
    inst_i = 32'h00862824; pc_i = 32'h108;
    set_ch(0, 1, 5'd4, 32'h0); set_ch(1, 0, 5'd0, 32'h0); ex_is_load_i = 1;
    #1 chk("t3 stallreq", stallreq_o, 1'b1);
    tick();
    chk("t3 bubble wreg", wreg_o, 1'b0);
    chk("t3 bubble aluop", aluop_o, EXE_NOP_OP);
    chk("t3 stall_cnt", stall_cnt_o, 16'd1);
    ex_is_load_i = 0; set_ch(0, 0, 5'd0, 32'h0); set_ch(1, 1, 5'd4, 32'h1234);
    tick();
    chk("t3 reg1", reg1_o, 32'h1234);
    chk("t3 wreg", wreg_o, 1'b1);

    // 4: nor $1,$0,$0 with a producer targeting $0
    inst_i = 32'h00000827; reg1_data_i = 32'h11111111; reg2_data_i = 32'h22222222;
    set_ch(0, 1, 5'd0, 32'hFFFFFFFF); set_ch(1, 0, 5'd0, 32'h0); ex_is_load_i = 1;
    #1 chk("t4 stallreq", stallreq_o, 1'b0);
    tick();
    chk("t4 reg1", reg1_o, 32'h0);
    chk("t4 reg2", reg2_o, 32'h0);
    ex_is_load_i = 0; set_ch(0, 0, 5'd0, 32'h0);

    // 5: hold, then flush over hold, then sll $2,$3,5
    inst_i = 32'h340700AB; tick();
    chk("t5 reg2", reg2_o, 32'h000000AB);
    ex_stall_i = 1; inst_i = 32'h34081234;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5 hold reg2", reg2_o, 32'h000000AB);
      chk("t5 hold wd", wd_o, 5'd7);
    end
    flush_i = 1; tick();
    chk("t5 flush wreg", wreg_o, 1'b0);
    chk("t5 flush reg2", reg2_o, 32'h0);
    flush_i = 0; ex_stall_i = 0; inst_i = 32'h00031140; reg2_data_i = 32'h80;
    tick();
    chk("t5 sll reg1", reg1_o, 32'd5);
    chk("t5 sll reg2", reg2_o, 32'h80);
    chk("t5 sll aluop", aluop_o, EXE_SLL_OP);

    // 6: invalid opcode, reset mid-stall, 2-bit saturation
    inst_i = 32'hFC000000; tick();
    chk("t6 inv", inst_invalid_o, 1'b1);
    chk("t6 inv wreg", wreg_o, 1'b0);
    inst_i = 32'h00862824; set_ch(0, 1, 5'd4, 32'h0); ex_is_load_i = 1;
    tick(); tick();
    rst = 1; tick();
    chk("t6 rst cnt", stall_cnt_o, 16'd0);
    chk("t6 rst pc", pc_o, 32'h0);
    chk("t6 rst wreg", wreg_o, 1'b0);
    rst = 0; ex_is_load_i = 0; set_ch(0, 0, 5'd0, 32'h0); inst_i = 32'h34011100;
    tick();
    chk("t6 post rst wreg", wreg_o, 1'b1);
    chk("t6 post rst reg2", reg2_o, 32'h1100);
    inst_i = 32'h00862824; set_ch(0, 1, 5'd4, 32'h0); ex_is_load_i = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6 cnt16", stall_cnt_o, 16'd5);
    chk("t6 cnt2 sat", b_stall_cnt_o, 2'd3);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      flush_i      = ($urandom_range(0, 19) == 0);
      ex_stall_i   = ($urandom_range(0, 6) == 0);
      valid_i      = ($urandom_range(0, 4) != 0);
      ex_is_load_i = ($urandom_range(0, 2) == 0);
      pc_i         = $urandom;
      inst_i       = rnd_inst();
      reg1_data_i  = $urandom;
      reg2_data_i  = $urandom;
      for (int k = 0; k < NF; k++)
        set_ch(k, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
Parametrised decode stage for the MIPS32 five-stage pipeline, with the ID/EX pipeline register built in. It decodes the logic and shift instruction set plus LW, and forwards operands from NUM_FWD in-flight producers in priority order. It also detects load-use hazards, raises a stall request and inserts bubbles. A saturating counter records how many cycles were lost to stalls.

Parameters:
NUM_FWD, 2, number of forwarding sources; channel 0 is the youngest producer (EX), higher indices are older (MEM, WB, ...).
CNT_W, 16, width of the stall-cycle performance counter.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-high
valid_i  in  1  inst_i/pc_i hold a real instruction
pc_i  in  32  instruction address
inst_i  in  32  instruction word
reg1_data_i  in  32  regfile read port 1 data
reg2_data_i  in  32  regfile read port 2 data
reg1_read_o  out  1  regfile port 1 read enable (combinational)
reg2_read_o  out  1  regfile port 2 read enable (combinational)
reg1_addr_o  out  5  regfile port 1 address, inst[25:21] (combinational)
reg2_addr_o  out  5  regfile port 2 address, inst[20:16] (combinational)
fwd_wreg_i  in  NUM_FWD  per-channel write enable
fwd_wd_i  in  5*NUM_FWD  per-channel destination; channel k in bits [5k+4:5k]
fwd_wdata_i  in  32*NUM_FWD  per-channel result; channel k in bits [32k+31:32k]
ex_is_load_i  in  1  the channel-0 producer is a load, so its data is not yet valid
ex_stall_i  in  1  downstream stall: hold the ID/EX register
flush_i  in  1  replace the ID/EX contents with a bubble
stallreq_o  out  1  load-use stall request (combinational); upstream holds pc/inst
aluop_o  out  8  registered ALU subtype
alusel_o  out  3  registered ALU type
reg1_o  out  32  registered operand 1
reg2_o  out  32  registered operand 2
wd_o  out  5  registered destination register
wreg_o  out  1  registered write enable
is_load_o  out  1  registered: the instruction is LW
pc_o  out  32  registered pc
inst_invalid_o  out  1  registered: unrecognised opcode
stall_cnt_o  out  CNT_W  count of load-use stall cycles

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Every registered output resets to 0; aluop/alusel reset to EXE_NOP_OP/EXE_RES_NOP; stall_cnt_o resets to 0.
- Decode is combinational from inst_i:
  - ORI/ANDI/XORI: reg1 = rs, reg2 = zero-extended imm, wd = rt.
  - LUI: reg1 = rs ($0), reg2 = {imm, 16'h0}, alu OR, wd = rt.
  - SPECIAL AND/OR/XOR/NOR/SLLV/SRLV/SRAV: reg1 = rs, reg2 = rt, wd = rd.
  - SLL/SRL/SRA: reg1 = {27'b0, sa}, reg2 = rt, wd = rd.
  - LW: reg1 = rs, reg2 = sign-extended imm, aluop EXE_LW_OP, alusel EXE_RES_LOAD_STORE, wd = rt, is_load = 1.
  - PREF/SYNC: valid NOP, wreg = 0.
  - Any other opcode: invalid, wreg = 0, NOP.
- When an operand's read enable is 0, the operand is taken from the immediate path above.
- Forwarding, evaluated per operand when its read enable is 1:
  - Address 0 always yields 0. No forwarding to $0, and reg*_data_i is ignored for $0.
  - Otherwise, the lowest-index channel k with fwd_wreg_i[k]=1 and fwd_wd_k equal to the address supplies the data.
  - If no channel matches, the operand is reg*_data_i.
- Load-use hazard: hazard = valid_i & ex_is_load_i & fwd_wreg_i[0] & (for either operand: read enable, address != 0, address == fwd_wd_0). stallreq_o = hazard & ~ex_stall_i.
- ID/EX register update, highest priority first:
  1. rst → reset values.
  2. flush_i → bubble.
  3. ex_stall_i → hold all outputs.
  4. hazard → bubble.
  5. valid_i → capture the decoded values.
  6. Otherwise → bubble.
- A bubble is NOP aluop/alusel, wreg = 0, is_load = 0, inst_invalid = 0, with operands, wd and pc forced to 0.
- Latency: one cycle from inst_i to the registered outputs.
- stall_cnt_o increments on every cycle in which stallreq_o is 1 and rst/flush_i are 0. It saturates at 2^CNT_W-1 and does not wrap.
- A reset in the middle of a stall clears everything; the first cycle after reset decodes normally.

Decomposition:
- defines.v: opcode/funct constants, EXE_*_OP and EXE_RES_* codes, and new EXE_LW / EXE_LW_OP / EXE_RES_LOAD_STORE.
- Sub-module id_fwd_mux (NUM_FWD parameter): does the address-0 check, the priority channel scan and the regfile fallback. It is instantiated once per operand.

Test Plan:
1. ori $1,$0,0x1100 (0x34011100), valid_i=1 → next cycle: reg1_o=0, reg2_o=0x00001100, aluop OR, wd_o=1, wreg_o=1.
2. or $3,$1,$2 with channel 0 (wd=1, data 0xAAAA0000) and channel 1 (wd=1, data 0x00005555), reg2_data_i=7 → reg1_o=0xAAAA0000 (channel 0 wins), reg2_o=7.
3. Channel 0 = LW writing $4 with ex_is_load_i=1; ID holds and $5,$4,$6 → stallreq_o=1, next cycle is a bubble and stall_cnt_o=1. Then drop ex_is_load_i and put data 0x1234 on channel 1 for $4 → instruction captured with reg1_o=0x1234.
4. Channel 0 targets $0 with data 0xFFFFFFFF; ID holds nor $1,$0,$0 → reg1_o=reg2_o=0, and no stall even with ex_is_load_i=1.
5. ex_stall_i=1 for 3 cycles → outputs frozen. Then flush_i and ex_stall_i asserted together → bubble (flush wins). sll $2,$3,5 → reg1_o=5.
6. Opcode 0x3F → inst_invalid_o=1, wreg_o=0. Assert rst during a load-use stall → all outputs 0 and stall_cnt_o=0 after one cycle. With CNT_W=2, a 5-cycle stall → stall_cnt_o=3.
